tl_param_queue: RTL

- Parametrised successor to the fixed 2-entry, 3-bit TileLink sink-id queue.
- Generalised in payload width and depth.
- Adds consumer back-pressure (`io_deq_ready`), flow-through and pipe modes, an occupancy count and a synchronous flush.
- Sits between TileLink channel producers and consumers (sink-id return paths, D/E channel decoupling) as the standard ready/valid FIFO.

---
 rtl/tl_queue_pkg.sv | 29 ++
 rtl/tl_param_queue_if.sv | 43 ++++
 rtl/tl_queue_ram.sv | 26 ++
 rtl/tl_param_queue.sv | 105 ++++++++++
 4 files changed

// File: rtl/tl_queue_pkg.sv
// Shared helpers for the parametrised TileLink ready/valid queue.
// Contents: width helpers (pointer and occupancy widths) and the mode
// encoding used to decode the FLOW/PIPE parameter bits.
package tl_queue_pkg;

   // Width of an index/counter able to address n values, never below 1 bit
   // so single-entry queues still get a legal vector.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // PW: pointer width for a DEPTH-entry queue.
   function automatic int ptr_width(input int depth);
      return clog2_min1(depth);
   endfunction

   // CW: occupancy width, able to hold 0..DEPTH.
   function automatic int count_width(input int depth);
      return clog2_min1(depth + 1);
   endfunction

   typedef enum logic [1:0] {
      MODE_BASE      = 2'b00,
      MODE_FLOW      = 2'b01,
      MODE_PIPE      = 2'b10,
      MODE_FLOW_PIPE = 2'b11
   } queue_mode_e;

endpackage

// File: rtl/tl_param_queue_if.sv
// Ready/valid bundle for tl_param_queue.
// master: producer/consumer side (drives enq_valid/bits, deq_ready, flush).
// slave : queue side (drives enq_ready, deq_valid/bits, count).
interface tl_param_queue_if #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 2
);
   import tl_queue_pkg::*;

   localparam int CW = count_width(DEPTH);

   logic             io_enq_ready;
   logic             io_enq_valid;
   logic [WIDTH-1:0] io_enq_bits;
   logic             io_deq_ready;
   logic             io_deq_valid;
   logic [WIDTH-1:0] io_deq_bits;
   logic             io_flush;
   logic [CW-1:0]    io_count;

   modport master (
      input  io_enq_ready,
      output io_enq_valid,
      output io_enq_bits,
      output io_deq_ready,
      input  io_deq_valid,
      input  io_deq_bits,
      output io_flush,
      input  io_count
   );

   modport slave (
      output io_enq_ready,
      input  io_enq_valid,
      input  io_enq_bits,
      input  io_deq_ready,
      output io_deq_valid,
      output io_deq_bits,
      input  io_flush,
      output io_count
   );

endinterface

// File: rtl/tl_queue_ram.sv
// DEPTH x WIDTH flop storage for the queue: one synchronous write port,
// one combinational read port. Kept separate so a memory macro can be
// swapped in later. Contents are intentionally not reset.
// Ports: clock, wr_en/wr_addr/wr_data (write), rd_addr/rd_data (read).
module tl_queue_ram #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 2,
   parameter int AW    = 1
) (
   input  logic             clock,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/tl_param_queue.sv
// Parametrised ready/valid FIFO for TileLink channel decoupling.
// Optional empty-queue bypass (FLOW) and full-queue pass-through (PIPE),
// occupancy output and synchronous flush.
// Ports: clock, reset (async, active-high), io (tl_param_queue_if.slave).
module tl_param_queue
   import tl_queue_pkg::*;
#(
   parameter int WIDTH = 3,
   parameter int DEPTH = 2,
   parameter bit FLOW  = 1'b0,
   parameter bit PIPE  = 1'b0
) (
   input  logic         clock,
   input  logic         reset,
   tl_param_queue_if.slave io
);

   localparam int          PW   = ptr_width(DEPTH);
   localparam int          CW   = count_width(DEPTH);
   localparam queue_mode_e MODE = queue_mode_e'({PIPE, FLOW});
   localparam bit FLOW_EN = (MODE == MODE_FLOW) || (MODE == MODE_FLOW_PIPE);
   localparam bit PIPE_EN = (MODE == MODE_PIPE) || (MODE == MODE_FLOW_PIPE);

   logic [PW-1:0]    enq_ptr_q, enq_ptr_d;
   logic [PW-1:0]    deq_ptr_q, deq_ptr_d;
   logic             maybe_full_q, maybe_full_d;
   logic             ptr_match, empty, full, flow_path;
   logic             enq_ready, deq_valid, do_enq, do_deq;
   logic [WIDTH-1:0] rd_data;
   logic [CW-1:0]    count;

   // Explicit wrap so non-power-of-2 depths cycle correctly.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (DEPTH == 1) return '0;
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   tl_queue_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_ram (
      .clock   (clock),
      .wr_en   (do_enq),
      .wr_addr (enq_ptr_q),
      .wr_data (io.io_enq_bits),
      .rd_addr (deq_ptr_q),
      .rd_data (rd_data)
   );

   always_comb begin
      ptr_match = (enq_ptr_q == deq_ptr_q);
      empty     = ptr_match & ~maybe_full_q;
      full      = ptr_match & maybe_full_q;
      flow_path = FLOW_EN & empty;

      enq_ready = (~full | (PIPE_EN & io.io_deq_ready)) & ~io.io_flush;
      // Reset gating matters only for the bypass path: registered state is
      // already empty while reset is held.
      deq_valid = (flow_path ? io.io_enq_valid : ~empty) & ~io.io_flush & ~reset;

      do_enq = io.io_enq_valid & enq_ready;
      do_deq = deq_valid & io.io_deq_ready;
      // Bypassed beat never touches storage or pointers.
      if (flow_path & io.io_deq_ready) begin
         do_enq = 1'b0;
         do_deq = 1'b0;
      end

      enq_ptr_d    = enq_ptr_q;
      deq_ptr_d    = deq_ptr_q;
      maybe_full_d = maybe_full_q;
      if (io.io_flush) begin
         enq_ptr_d    = '0;
         deq_ptr_d    = '0;
         maybe_full_d = 1'b0;
      end else begin
         if (do_enq) enq_ptr_d = ptr_inc(enq_ptr_q);
         if (do_deq) deq_ptr_d = ptr_inc(deq_ptr_q);
         if (do_enq != do_deq) maybe_full_d = do_enq;
      end

      if (ptr_match) count = maybe_full_q ? CW'(DEPTH) : '0;
      else if (enq_ptr_q > deq_ptr_q) count = CW'(enq_ptr_q) - CW'(deq_ptr_q);
      else count = CW'(DEPTH) + CW'(enq_ptr_q) - CW'(deq_ptr_q);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         enq_ptr_q    <= '0;
         deq_ptr_q    <= '0;
         maybe_full_q <= 1'b0;
      end else begin
         enq_ptr_q    <= enq_ptr_d;
         deq_ptr_q    <= deq_ptr_d;
         maybe_full_q <= maybe_full_d;
      end
   end

   assign io.io_enq_ready = enq_ready;
   assign io.io_deq_valid = deq_valid;
   assign io.io_deq_bits  = flow_path ? io.io_enq_bits : rd_data;
   assign io.io_count     = count;

endmodule
